data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; power of two, 4..4096.
REQ-002 Parameter ADDR_W, default 32: byte-address width; SHALL be at least log2(DEPTH)+2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 MemRead  input  1  read request, sampled on clk.
REQ-006 MemWrite  input  1  write request, sampled on clk.
REQ-007 Size  input  2  access size: 00 byte, 01 half, 10 word; 11 reserved.
REQ-008 Unsigned  input  1  1 = zero-extend byte/half loads; 0 = sign-extend.
REQ-009 Adress  input  ADDR_W  byte address.
REQ-010 WriteD  input  32  store data; byte/half taken from low bits.
REQ-011 Ready  output  1  1 = requests accepted this cycle.
REQ-012 Rdata  output  32  load result, extended per Size/Unsigned.
REQ-013 RValid  output  1  one-cycle pulse, Rdata valid.
REQ-014 Misalign  output  1  one-cycle pulse, rejected misaligned request.
REQ-015 OutOfRange  output  1  one-cycle pulse, rejected request with word index >= DEPTH or Size=11.

Function
REQ-016 FSM states: CLEAR, IDLE; reset enters CLEAR with clear index 0.
REQ-017 CLEAR: write 0 to word[index] each cycle; index increments; after index DEPTH-1 go to IDLE; Ready=0 throughout.
REQ-018 IDLE: Ready=1; requests accepted only when Ready=1; requests while Ready=0 are ignored with no flags.
REQ-019 Word index = Adress[log2(DEPTH)+1:2]; byte lane = Adress[1:0], little-endian (lane 0 = bits 7:0).
REQ-020 Misaligned: half with Adress[0]=1; word with Adress[1:0]!=00.
REQ-021 Out of range: any Adress bit above index field set, or Size=11; OutOfRange takes priority over Misalign.
REQ-022 Accepted write, legal: update only addressed lanes at the clock edge; other lanes unchanged.
REQ-023 Accepted read, legal: RValid=1 and Rdata updated exactly one cycle after acceptance (latency 1).
REQ-024 Rdata holds its last value between reads; RValid=0 otherwise.
REQ-025 Byte load: selected lane in bits 7:0, bits 31:8 = sign of bit 7 or zero per Unsigned; half likewise on bits 15:0.
REQ-026 Rejected request: no memory update, no RValid; error flag pulses one cycle after acceptance.
REQ-027 MemRead and MemWrite both 1: treated as write only; no RValid.
REQ-028 Read in cycle N+1 to address written in cycle N returns new data (no stale read).
REQ-029 Back-to-back reads sustain one per cycle.

Reset
REQ-030 rst=1: Ready=0, Rdata=0, RValid=0, Misalign=0, OutOfRange=0, state CLEAR, index 0.
REQ-031 rst during CLEAR restarts clear at index 0; rst with read in flight drops that RValid.
REQ-032 Memory contents reach all-zero only via CLEAR, DEPTH cycles after rst deasserts.

Structure
REQ-033 Package data_mem_pkg holds Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum.
REQ-034 One sub-module mem_load_align: combinational lane select and sign/zero extension.
REQ-035 Storage as a single word array with per-byte write enables; no reset of the array itself.

Verification
REQ-036 rst 1 cycle, DEPTH=256 -> Ready=0 for 256 cycles, then 1; read word 0x3FC -> Rdata=0x00000000.
REQ-037 Word write 0x11223344 @0x10; byte write 0xAA @0x11; word read @0x10 -> RValid next cycle, Rdata=0x1122AA44.
REQ-038 Store 0x000080F0 as half @0x20; read half @0x20 Unsigned=0 -> 0xFFFF80F0; Unsigned=1 -> 0x000080F0; byte @0x21 signed -> 0xFFFFFF80.
REQ-039 Word read @0x22 -> Misalign pulse, no RValid; word write @0x400 (DEPTH=256) -> OutOfRange pulse, memory unchanged.
REQ-040 rst asserted at clear index 100 -> clear restarts at 0, Ready rises exactly 256 cycles after rst deasserts; read issued before rst -> no RValid.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller.
// Access-size codes, FSM states and lane helpers.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Byte enables for a store of the given size at a byte lane.
    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated onto every lane it may land in.
    function automatic logic [31:0] store_lanes(
        input logic [1:0]  size,
        input logic [31:0] data
    );
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{data[7:0]}};
            SZ_HALF: w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/half out of a word and
// sign- or zero-extends it. Ports: word_i, size_i, lane_i, unsigned_i -> data_o.
module mem_load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sgn;

    always_comb begin
        byte_v = word_i[{lane_i, 3'b000} +: 8];
        half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;
        sgn    = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                sgn    = ~unsigned_i & byte_v[7];
                data_o = {{24{sgn}}, byte_v};
            end
            SZ_HALF: begin
                sgn    = ~unsigned_i & half_v[15];
                data_o = {{16{sgn}}, half_v};
            end
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access, self-clear after
// reset, range/alignment checks. Ports: clk, rst, MemRead, MemWrite, Size,
// Unsigned, Adress, WriteD -> Ready, Rdata, RValid, Misalign, OutOfRange.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Adress,
    input  logic [31:0]       WriteD,
    output logic              Ready,
    output logic [31:0]       Rdata,
    output logic              RValid,
    output logic              Misalign,
    output logic              OutOfRange
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [3:0][7:0] mem_q [DEPTH];

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Ready is also masked by rst so nothing lands during the reset cycle.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        Ready     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: Ready = ~rst;
        endcase
    end

    logic             req, oor, mis, do_wr, do_rd;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;

    assign req  = Ready & (MemRead | MemWrite);
    assign idx  = Adress[IDX_W+1:2];
    assign lane = Adress[1:0];
    assign oor  = (Size == SZ_RSVD) | (|(Adress >> (IDX_W + 2)));
    assign mis  = ((Size == SZ_HALF) & Adress[0])
                | ((Size == SZ_WORD) & (Adress[1:0] != 2'b00));

    assign do_wr = req & MemWrite & ~oor & ~mis;
    assign do_rd = req & MemRead & ~MemWrite & ~oor & ~mis;

    // Single write port shared by the clear sweep and stores.
    logic [3:0]       wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;

    always_comb begin
        wr_en   = 4'b0000;
        wr_idx  = idx;
        wr_data = '0;
        if (state_q == ST_CLEAR) begin
            wr_en  = 4'b1111;
            wr_idx = clr_idx_q;
        end else if (do_wr) begin
            wr_en   = byte_en(Size, lane);
            wr_data = store_lanes(Size, WriteD);
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) begin
                mem_q[wr_idx][b] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Raw word and access attributes are captured; alignment happens
    // after the register so Rdata holds between reads.
    logic [31:0] rd_word_q;
    logic [1:0]  rd_size_q;
    logic [1:0]  rd_lane_q;
    logic        rd_uns_q;
    logic        rvalid_q, mis_q, oor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q <= '0;
            rd_size_q <= SZ_WORD;
            rd_lane_q <= 2'b00;
            rd_uns_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            mis_q     <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            rvalid_q <= do_rd;
            mis_q    <= req & ~oor & mis;
            oor_q    <= req & oor;
            if (do_rd) begin
                rd_word_q <= mem_q[idx];
                rd_size_q <= Size;
                rd_lane_q <= lane;
                rd_uns_q  <= Unsigned;
            end
        end
    end

    mem_load_align u_align (
        .word_i     (rd_word_q),
        .size_i     (rd_size_q),
        .lane_i     (rd_lane_q),
        .unsigned_i (rd_uns_q),
        .data_o     (Rdata)
    );

    assign RValid     = rvalid_q;
    assign Misalign   = mis_q;
    assign OutOfRange = oor_q;

endmodule
